// File: rtl/dpwm_pkg.sv
// rtl/dpwm_pkg.sv - shared constants and FSM state type for the DPWM gate monitor
package dpwm_pkg;

    localparam int CW_DEF        = 8;
    localparam int MIN_DT_DEF    = 2;
    localparam int TIMEOUT_DEF   = 200;
    localparam int DPWM_PERIOD   = 64;
    localparam int DPWM_DEADTIME = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_DT1  = 3'd2,
        ST_LOW  = 3'd3,
        ST_DT2  = 3'd4
    } state_t;

endpackage

// File: rtl/dpwm_gate_monitor_gate_sync_edge.sv
// rtl/dpwm_gate_monitor_gate_sync_edge.sv - gate input synchronizer with rise/fall detect
module gate_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic s_out,
    output logic rise,
    output logic fall
);

    logic dly_q;
    logic dly_d;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s_out = d_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            // shift the raw gate into the synchronizer chain
            always_comb begin
                sync_d    = sync_q << 1;
                sync_d[0] = d_in;
            end

            // synchronizer flops
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '0;
                else     sync_q <= sync_d;
            end

            assign s_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // one-cycle delayed copy used for edge detection
    always_comb begin
        dly_d = s_out;
    end

    // delay flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dly_q <= 1'b0;
        else     dly_q <= dly_d;
    end

    assign rise = s_out & ~dly_q;
    assign fall = ~s_out & dly_q;

endmodule

// File: rtl/dpwm_gate_monitor.sv
// rtl/dpwm_gate_monitor.sv - decodes a complementary gate pair into per-period timing
module dpwm_gate_monitor
    import dpwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = CW_DEF,
    parameter int MIN_DT      = MIN_DT_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gate_h,
    input  logic          gate_l,
    input  logic          clr_flags,
    output logic          meas_valid,
    output logic [CW-1:0] t_high,
    output logic [CW-1:0] dt_hl,
    output logic [CW-1:0] t_low,
    output logic [CW-1:0] dt_lh,
    output logic [CW-1:0] period,
    output logic          shoot_through,
    output logic          dt_short,
    output logic          seq_err,
    output logic          stall
);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] MIN_DT_C  = CW'(MIN_DT);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    logic gh_s, gh_rise, gh_fall;
    logic gl_s, gl_rise, gl_fall;

    gate_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h (
        .clk   (clk),
        .rst   (rst),
        .d_in  (gate_h),
        .s_out (gh_s),
        .rise  (gh_rise),
        .fall  (gh_fall)
    );

    gate_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
        .clk   (clk),
        .rst   (rst),
        .d_in  (gate_l),
        .s_out (gl_s),
        .rise  (gl_rise),
        .fall  (gl_fall)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] seg_q, seg_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [CW-1:0] th_q, th_d;
    logic [CW-1:0] dthl_q, dthl_d;
    logic [CW-1:0] tl_q, tl_d;
    logic          mv_q, mv_d;
    logic [CW-1:0] t_high_q, t_high_d;
    logic [CW-1:0] dt_hl_q, dt_hl_d;
    logic [CW-1:0] t_low_q, t_low_d;
    logic [CW-1:0] dt_lh_q, dt_lh_d;
    logic [CW-1:0] period_q, period_d;
    logic          st_q, st_d;
    logic          dts_q, dts_d;
    logic          seq_q, seq_d;
    logic          stall_q, stall_d;

    logic          close;
    logic          seq_set;
    logic          dts_set;
    logic [CW-1:0] c_dthl, c_tl, c_dtlh;

    // edge-driven period decoder, measurement capture and flag update
    always_comb begin
        state_d  = state_q;
        per_d    = sat_inc(per_q);
        seg_d    = sat_inc(seg_q);
        idle_d   = gh_rise ? '0 : sat_inc(idle_q);
        th_d     = th_q;
        dthl_d   = dthl_q;
        tl_d     = tl_q;
        mv_d     = 1'b0;
        t_high_d = t_high_q;
        dt_hl_d  = dt_hl_q;
        t_low_d  = t_low_q;
        dt_lh_d  = dt_lh_q;
        period_d = period_q;
        stall_d  = stall_q;
        close    = 1'b0;
        seq_set  = 1'b0;
        dts_set  = 1'b0;
        c_dthl   = dthl_q;
        c_tl     = tl_q;
        c_dtlh   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gh_rise) begin
                    state_d = ST_HIGH;
                    per_d   = ONE;
                    seg_d   = ONE;
                end
            end
            ST_HIGH: begin
                if (gh_fall) begin
                    th_d    = seg_q;
                    seg_d   = ONE;
                    state_d = ST_DT1;
                end
            end
            ST_DT1: begin
                if (gh_rise) begin
                    // low pulse skipped: whole off time is the H->L gap
                    close  = 1'b1;
                    c_dthl = seg_q;
                    c_tl   = '0;
                    c_dtlh = '0;
                end else if (gl_rise) begin
                    dthl_d  = seg_q;
                    seg_d   = ONE;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (gh_rise) begin
                    seq_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (gl_fall) begin
                    tl_d    = seg_q;
                    seg_d   = ONE;
                    state_d = ST_DT2;
                end
            end
            ST_DT2: begin
                if (gh_rise) begin
                    close  = 1'b1;
                    c_dtlh = seg_q;
                end else if (gl_rise) begin
                    seq_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (close) begin
            mv_d     = 1'b1;
            t_high_d = th_q;
            dt_hl_d  = c_dthl;
            t_low_d  = c_tl;
            dt_lh_d  = c_dtlh;
            period_d = per_q;
            dts_set  = (c_tl != '0) && ((c_dthl < MIN_DT_C) || (c_dtlh < MIN_DT_C));
            state_d  = ST_HIGH;
            per_d    = ONE;
            seg_d    = ONE;
        end

        if (gh_rise) begin
            stall_d = 1'b0;
        end else if (idle_d >= TIMEOUT_C) begin
            stall_d = 1'b1;
            state_d = ST_IDLE;
        end

        st_d  = (gh_s & gl_s) | (st_q & ~clr_flags);
        dts_d = dts_set | (dts_q & ~clr_flags);
        seq_d = seq_set | (seq_q & ~clr_flags);
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            per_q    <= '0;
            seg_q    <= '0;
            idle_q   <= '0;
            th_q     <= '0;
            dthl_q   <= '0;
            tl_q     <= '0;
            mv_q     <= 1'b0;
            t_high_q <= '0;
            dt_hl_q  <= '0;
            t_low_q  <= '0;
            dt_lh_q  <= '0;
            period_q <= '0;
            st_q     <= 1'b0;
            dts_q    <= 1'b0;
            seq_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            seg_q    <= seg_d;
            idle_q   <= idle_d;
            th_q     <= th_d;
            dthl_q   <= dthl_d;
            tl_q     <= tl_d;
            mv_q     <= mv_d;
            t_high_q <= t_high_d;
            dt_hl_q  <= dt_hl_d;
            t_low_q  <= t_low_d;
            dt_lh_q  <= dt_lh_d;
            period_q <= period_d;
            st_q     <= st_d;
            dts_q    <= dts_d;
            seq_q    <= seq_d;
            stall_q  <= stall_d;
        end
    end

    assign meas_valid    = mv_q;
    assign t_high        = t_high_q;
    assign dt_hl         = dt_hl_q;
    assign t_low         = t_low_q;
    assign dt_lh         = dt_lh_q;
    assign period        = period_q;
    assign shoot_through = st_q;
    assign dt_short      = dts_q;
    assign seq_err       = seq_q;
    assign stall         = stall_q;

endmodule

// File: doc/dpwm_gate_monitor.md
Name: dpwm_gate_monitor

Overview:
- Receive-side companion to the deadtime DPWM: decodes the complementary gate pair (gate_h, gate_l) back into measured timing.
- Per switching period it reports high-side on-time, H→L deadtime, low-side on-time, L→H deadtime and total period, all in clk cycles.
- Sticky flags report shoot-through, short deadtime and sequence errors; a stall flag reports loss of switching.
- Sits beside the DPWM, feeding the compensator/diagnostics path.

Parameters:
SYNC_STAGES, 2, input synchronizer depth for gate_h/gate_l (0 = inputs already in clk domain, use directly)
CW, 8, width of every measurement counter/output
MIN_DT, 2, minimum legal deadtime in cycles; smaller → dt_short
TIMEOUT, 200, cycles without gate_h rise before stall; must be ≤ 2^CW-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
gate_h  in  1  high-side gate drive
gate_l  in  1  low-side gate drive
clr_flags  in  1  synchronous clear of sticky flags
meas_valid  out  1  one-cycle pulse: new measurement set on outputs
t_high  out  CW  gate_h high cycles
dt_hl  out  CW  cycles from gate_h fall to gate_l rise
t_low  out  CW  gate_l high cycles
dt_lh  out  CW  cycles from gate_l fall to next gate_h rise
period  out  CW  cycles between consecutive gate_h rises
shoot_through  out  1  sticky: gate_h and gate_l sampled high in same cycle
dt_short  out  1  sticky: completed dt_hl or dt_lh < MIN_DT
seq_err  out  1  sticky: illegal edge order
stall  out  1  level: no gate_h rise for TIMEOUT cycles

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs 0, synchronizers 0, FSM IDLE, counters 0.
- gh_s/gl_s = synchronized inputs; rise/fall detected against a 1-cycle delayed copy. All durations are counted on gh_s/gl_s and equal raw-input durations.
- FSM states: IDLE, HIGH, DT1, LOW, DT2.
  - IDLE: wait for gh rise → HIGH. Counters start; no meas_valid on this first rise.
  - HIGH: gh fall → DT1.
  - DT1: gl rise → LOW. gh rise → period closes with t_low=0, dt_lh=0 (low pulse skipped, legal).
  - LOW: gl fall → DT2.
  - DT2: gh rise → period closes. gl rise → seq_err, measurement discarded, → IDLE.
- Any gh rise outside HIGH/DT1/DT2/IDLE (e.g. in LOW) → seq_err, discard, → IDLE.
- Period close:
  - In the rise-detect cycle, register all five fields and pulse meas_valid for 1 cycle.
  - FSM → HIGH and counters restart, so back-to-back periods lose no cycles.
  - Latency: meas_valid high SYNC_STAGES+1 clk edges after the edge that first samples raw gate_h=1 (counting that edge).
- Output fields hold their value between meas_valid pulses.
- Counters saturate at 2^CW-1; no wrap.
- shoot_through: set any cycle gh_s&gl_s, in any state.
- dt_short: evaluated at close; a skipped low pulse (t_low=0) is exempt.
- clr_flags clears sticky flags. If a set condition occurs in the same cycle as clr_flags, set wins.
- stall: cycles since last gh rise (or since reset) reach TIMEOUT → stall=1, FSM → IDLE, no meas_valid. stall clears on the next gh rise; the next valid period needs one further rise.
- rst mid-period: immediate return to reset state; the partial period is never reported.

Decomposition:
- Shared package dpwm_pkg: FSM state enum, CW default, MIN_DT/TIMEOUT defaults, DPWM period constant 64, deadtime constant 6.
- One sub-module: gate_sync_edge (SYNC_STAGES flop chain plus rise/fall detect), instantiated once per gate input.

Test Plan:
- DPWM model, period 64, deadtime 6, d=20, SYNC_STAGES=2 → from 2nd period every 64 cycles: meas_valid; t_high=20, dt_hl=6, t_low=32, dt_lh=6, period=64; all flags 0.
- d=55 (d+6 ≥ 58, low pulse absent) → t_high=55, dt_hl=9, t_low=0, dt_lh=0, period=64; dt_short=0.
- d=0 (gate_h never high) → no meas_valid; stall=1 at cycle TIMEOUT=200 after last rise; restore d=20 → stall clears on rise, meas_valid returns one period later.
- Force gate_l high 3 cycles overlapping gate_h → shoot_through=1 and stays 1; clr_flags pulse → 0; clr_flags coincident with new overlap → stays 1.
- Deadtime 1 instead of 6 → dt_short=1 at period close; gate_l double pulse in one period → seq_err=1, no meas_valid for that period.
- Assert rst mid-LOW, release → all outputs 0; first meas_valid only after two subsequent gate_h rises.
